// File: rtl/tmac_stoch_decoder.sv
// tmac_stoch_decoder: counts the 1s of a unipolar stochastic bitstream over a
// window of 2^WIDTH qualified bits and presents the count through a
// valid/ready handshake.
// Optional build macro TMAC_STOCH_DEC_BIPOLAR_EN: result is reported as the
// two's-complement bipolar value 2*count - 2^WIDTH instead of the raw count.
module tmac_stoch_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStart,
    input  logic             iBit,
    input  logic             iValid,
    output logic             oBusy,
    output logic [WIDTH+1:0] oData,
    output logic             oValid,
    input  logic             iReady
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH+1:0]   data_q, data_d;

    logic               last_bit;
    logic [WIDTH:0]     acc_next;

`ifdef TMAC_STOCH_DEC_BIPOLAR_EN
    // Map a unipolar count 0..2^WIDTH onto -2^WIDTH..+2^WIDTH.
    function automatic logic [WIDTH+1:0] format_result(input logic [WIDTH:0] count);
        logic signed [WIDTH+1:0] twice;
        logic signed [WIDTH+1:0] offset;
        twice  = signed'({count, 1'b0});
        offset = signed'({2'b01, {WIDTH{1'b0}}});
        return unsigned'(twice - offset);
    endfunction
`else
    // Unipolar result: the count zero-extended to the output width.
    function automatic logic [WIDTH+1:0] format_result(input logic [WIDTH:0] count);
        return {1'b0, count};
    endfunction
`endif

    // The window closes on the qualified bit that brings the count to 2^WIDTH.
    assign last_bit = iValid && (cnt_q == {WIDTH{1'b1}});
    assign acc_next = acc_q + {{WIDTH{1'b0}}, iBit};

    // State, counters and result register; reset discards any partial window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; iStart is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (iStart)          state_d = S_RUN;
            S_RUN:   if (last_bit)        state_d = S_HOLD;
            S_HOLD:  if (iReady)          state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // Datapath: clear on start, accumulate qualified bits, capture at window end.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        data_d = data_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    cnt_d = '0;
                    acc_d = '0;
                end
            end
            S_RUN: begin
                if (iValid) begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = acc_next;
                end
                if (last_bit) begin
                    data_d = format_result(acc_next);
                end
            end
            default: ;
        endcase
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        oBusy  = (state_q == S_RUN);
        oValid = (state_q == S_HOLD);
        oData  = data_q;
    end

endmodule

// File: doc/tmac_stoch_decoder.md
Name: tmac_stoch_decoder

Overview:
- Bitstream-to-binary decoder at the receiving end of the stochastic MAC output stream (oC of the unipolar MAC array).
- Counts the 1s in a unipolar stochastic stream over a fixed window of 2^WIDTH qualified bits.
- Returns the count as a binary value through a valid/ready output handshake.
- Sits between the MAC output and the binary result collector; one instance per MAC lane.

Parameters:
- WIDTH, 8, log2 of window length; window = 2^WIDTH qualified bits; matches MAC operand/RNG width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; one clock; reset is synchronous and active-high
- iStart  input  1  request to begin a new window; honoured only in IDLE
- iBit  input  1  stochastic bit from MAC (oC)
- iValid  input  1  iBit qualifier; only bits with iValid=1 are counted toward the window
- oBusy  output  1  high in RUN
- oData  output  WIDTH+2  decoded result; 0..2^WIDTH unipolar, zero-extended
- oValid  output  1  result available (HOLD state)
- iReady  input  1  consumer accepts oData when oValid & iReady

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; oBusy=0, oValid=0, oData=0; sample counter=0; ones accumulator=0. Reset overrides all other inputs, including mid-RUN and mid-HOLD; any partial window is discarded.
- Internal state:
  - sample counter: WIDTH bits, counts qualified bits.
  - ones accumulator: WIDTH+1 bits, so the full count 2^WIDTH is representable.
- FSM IDLE -> RUN:
  - Transition on iStart=1.
  - Same edge clears the sample counter and the accumulator.
  - iBit/iValid on the iStart cycle are not sampled.
- RUN, each cycle with iValid=1:
  - accumulator += iBit.
  - sample counter += 1.
  - Cycles with iValid=0 change nothing.
- RUN -> HOLD:
  - Transition on the qualified cycle where sample counter == 2^WIDTH-1.
  - That last bit is included.
  - oData is registered with the final count on the same edge.
  - oValid=1 from the next cycle.
  - Latency: start + 2^WIDTH qualified cycles, then oValid.
- HOLD:
  - oData stable and oValid held while iReady=0.
  - On oValid & iReady: transfer; HOLD -> IDLE; oValid=0 next cycle; oData retains its last value.
- iStart in RUN or HOLD is ignored, including HOLD with iReady=1 in the same cycle. A new window needs iStart in IDLE, so back-to-back windows cost one idle cycle minimum.
- iBit is ignored outside RUN.
- No overflow is possible: accumulator max = 2^WIDTH exactly.

Optional Feature:
- Macro: TMAC_STOCH_DEC_BIPOLAR_EN.
- Defined:
  - oData is a two's-complement bipolar value: 2*count - 2^WIDTH.
  - Range -2^WIDTH..+2^WIDTH in WIDTH+2 bits.
  - Computed when registering at RUN->HOLD; no added latency.
  - Reset value of oData stays 0.
- Undefined: oData = count zero-extended (unipolar). Identical port list in both builds.

Test Plan (WIDTH=8):
1. Run all-ones then all-zeros windows:
   - iStart, then 256 cycles iValid=1, iBit=1 -> oValid rises on cycle 258 after iStart; oData=256. Unipolar build: 0x100; bipolar build: +256.
   - Then iReady=1 -> oValid=0 next cycle.
   - iBit=0 for a full window -> oData=0 (bipolar: -256 = 10'h300).
2. Alternating iBit 1,0 with iValid toggling every other cycle:
   - Only qualified bits counted; qualified pattern all 1s for 128 and 0 for 128 -> oData=128 (bipolar 0).
   - Total window duration 512 cycles.
3. Backpressure: complete a window with count 77, hold iReady=0 for 20 cycles:
   - oValid=1 and oData=77 stable throughout.
   - iStart pulses during HOLD ignored; oBusy stays 0.
   - iReady=1 -> IDLE.
4. Reset mid-RUN: assert rst after 100 qualified bits:
   - Next cycle all outputs 0, state IDLE.
   - New iStart + 256 ones -> oData=256 (no residue from the aborted window).
5. iStart during RUN at bit 50 -> ignored; window ends after 256 total qualified bits with the correct count.
6. End-to-end: drive iBit from the MAC oC with all 16 A=B=255 products → decoded count matches the binary sum-comparator expectation ±1 LSB.
